// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the memory port arbiter: the arbiter FSM state encoding,
// the last-grant marker used for alternating priority, and the byte-enable
// pattern used for every full-word access (ifetch and data reads).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        D_BUSY,
        I_BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_INST,
        GRANT_DATA
    } grant_t;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/bus_timeout.sv
// ---------------------------------------------------------------------------
// bus_timeout
// Wait-cycle counter for an outstanding memory request. It counts the
// cycles spent waiting for the memory controller and flags the last
// permitted wait cycle so the arbiter can give up with a bus error.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   clear     : synchronous clear (highest priority)
//   enable    : count one more wait cycle
//   terminal  : high while the count equals TIMEOUT-1
// ---------------------------------------------------------------------------
module bus_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturate at TIMEOUT so a stuck enable can never wrap back to zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_W'(TIMEOUT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory bus between the instruction-fetch port and
// the data port. Data wins over ifetch, except that after a data grant a
// simultaneous ifetch is served first, so neither side can starve.
// Ports:
//   CLK, RESET              : clock, asynchronous active-high reset
//   I_REQ/I_ADDR            : ifetch request (held until I_ACK)
//   I_RDATA/I_ACK/I_ERR     : ifetch response (RDATA/ERR valid with ACK)
//   D_RE/D_WE/D_ADDR/D_WD/D_BE : data request (held until D_ACK)
//   D_RDATA/D_ACK/D_ERR     : data response (RDATA/ERR valid with ACK)
//   INHIBIT                 : blocks issue of a new data access
//   M_REQ/M_WE/M_ADDR/M_WD/M_BE : memory bus request, stable while busy
//   M_RDATA/M_READY/M_ERR   : memory bus completion
//   STALL                   : combinational pipeline hold
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic [31:0]       I_RDATA,
    output logic              I_ACK,
    output logic              I_ERR,
    input  logic              D_RE,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [31:0]       D_WD,
    input  logic [3:0]        D_BE,
    output logic [31:0]       D_RDATA,
    output logic              D_ACK,
    output logic              D_ERR,
    input  logic              INHIBIT,
    output logic              M_REQ,
    output logic              M_WE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [31:0]       M_WD,
    output logic [3:0]        M_BE,
    input  logic [31:0]       M_RDATA,
    input  logic              M_READY,
    input  logic              M_ERR,
    output logic              STALL
);

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [31:0]       m_wd_q, m_wd_d;
    logic [3:0]        m_be_q, m_be_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              i_err_q, i_err_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              d_ack_q, d_ack_d;
    logic              d_err_q, d_err_d;

    logic d_req;
    logic d_valid;
    logic busy;
    logic timeout_hit;

    assign d_req   = D_RE | D_WE;
    assign d_valid = d_req & ~INHIBIT;
    assign busy    = (state_q == D_BUSY) || (state_q == I_BUSY);

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (CLK),
        .rst      (RESET),
        .clear    (~busy),
        .enable   (busy & ~M_READY),
        .terminal (timeout_hit)
    );

    // Next-state logic. ACK and ERR default low so they pulse for exactly
    // the RESP cycle; read data registers hold their value otherwise.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wd_d       = m_wd_q;
        m_be_d       = m_be_q;
        i_rdata_d    = i_rdata_q;
        i_ack_d      = 1'b0;
        i_err_d      = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // Data normally wins; a data grant last time hands a tie to ifetch.
                if (d_valid && (!I_REQ || (last_grant_q == GRANT_INST))) begin
                    state_d      = D_BUSY;
                    last_grant_d = GRANT_DATA;
                    m_req_d      = 1'b1;
                    m_we_d       = D_WE;
                    m_addr_d     = D_ADDR;
                    m_wd_d       = D_WE ? D_WD : 32'h0;
                    m_be_d       = D_WE ? D_BE : BE_ALL;
                end else if (I_REQ) begin
                    state_d      = I_BUSY;
                    last_grant_d = GRANT_INST;
                    m_req_d      = 1'b1;
                    m_we_d       = 1'b0;
                    m_addr_d     = I_ADDR;
                    m_wd_d       = 32'h0;
                    m_be_d       = BE_ALL;
                end
            end
            D_BUSY, I_BUSY: begin
                // A real completion beats a timeout landing on the same cycle.
                if (M_READY || timeout_hit) begin
                    state_d = RESP;
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    if (state_q == D_BUSY) begin
                        d_ack_d = 1'b1;
                        d_err_d = M_READY ? M_ERR : 1'b1;
                        if (M_READY && !m_we_q) begin
                            d_rdata_d = M_RDATA;
                        end
                    end else begin
                        i_ack_d = 1'b1;
                        i_err_d = M_READY ? M_ERR : 1'b1;
                        if (M_READY) begin
                            i_rdata_d = M_RDATA;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single state/output register bank; reset aborts any transfer at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_INST;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wd_q       <= '0;
            m_be_q       <= '0;
            i_rdata_q    <= '0;
            i_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            d_rdata_q    <= '0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wd_q       <= m_wd_d;
            m_be_q       <= m_be_d;
            i_rdata_q    <= i_rdata_d;
            i_ack_q      <= i_ack_d;
            i_err_q      <= i_err_d;
            d_rdata_q    <= d_rdata_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
        end
    end

    assign M_REQ   = m_req_q;
    assign M_WE    = m_we_q;
    assign M_ADDR  = m_addr_q;
    assign M_WD    = m_wd_q;
    assign M_BE    = m_be_q;
    assign I_RDATA = i_rdata_q;
    assign I_ACK   = i_ack_q;
    assign I_ERR   = i_err_q;
    assign D_RDATA = d_rdata_q;
    assign D_ACK   = d_ack_q;
    assign D_ERR   = d_err_q;

    // A data request held off by INHIBIT does not stall, unless it is
    // already on the bus and must be waited for.
    assign STALL = (I_REQ & ~I_ACK)
                 | (d_req & ~D_ACK & (~INHIBIT | (state_q == D_BUSY)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives the arbiter with directed and randomized ifetch/data traffic and a
// behavioural memory responder, predicting grants, bus fields, latency,
// response data and errors from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 30;
    localparam int TIMEOUT = 4;

    logic              CLK;
    logic              RESET;
    logic              I_REQ;
    logic [ADDR_W-1:0] I_ADDR;
    logic [31:0]       I_RDATA;
    logic              I_ACK;
    logic              I_ERR;
    logic              D_RE;
    logic              D_WE;
    logic [ADDR_W-1:0] D_ADDR;
    logic [31:0]       D_WD;
    logic [3:0]        D_BE;
    logic [31:0]       D_RDATA;
    logic              D_ACK;
    logic              D_ERR;
    logic              INHIBIT;
    logic              M_REQ;
    logic              M_WE;
    logic [ADDR_W-1:0] M_ADDR;
    logic [31:0]       M_WD;
    logic [3:0]        M_BE;
    logic [31:0]       M_RDATA;
    logic              M_READY;
    logic              M_ERR;
    logic              STALL;

    int testsRun;
    int testsFailed;

    // Requester intent and reference-model state
    bit                iPend;
    logic [ADDR_W-1:0] iAddrM;
    bit                dPend;
    bit                dWrite;
    logic [ADDR_W-1:0] dAddrM;
    logic [31:0]       dWdM;
    logic [3:0]        dBeM;
    bit                inhibitM;
    bit                lastWasData;
    logic [31:0]       iRdModel;
    logic [31:0]       dRdModel;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .I_REQ   (I_REQ),
        .I_ADDR  (I_ADDR),
        .I_RDATA (I_RDATA),
        .I_ACK   (I_ACK),
        .I_ERR   (I_ERR),
        .D_RE    (D_RE),
        .D_WE    (D_WE),
        .D_ADDR  (D_ADDR),
        .D_WD    (D_WD),
        .D_BE    (D_BE),
        .D_RDATA (D_RDATA),
        .D_ACK   (D_ACK),
        .D_ERR   (D_ERR),
        .INHIBIT (INHIBIT),
        .M_REQ   (M_REQ),
        .M_WE    (M_WE),
        .M_ADDR  (M_ADDR),
        .M_WD    (M_WD),
        .M_BE    (M_BE),
        .M_RDATA (M_RDATA),
        .M_READY (M_READY),
        .M_ERR   (M_ERR),
        .STALL   (STALL)
    );

    // Free-running 10-time-unit clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Copy requester intent onto the DUT pins
    task automatic driveRequests();
        I_REQ   = iPend;
        I_ADDR  = iAddrM;
        D_RE    = dPend && !dWrite;
        D_WE    = dPend && dWrite;
        D_ADDR  = dAddrM;
        D_WD    = dWdM;
        D_BE    = dBeM;
        INHIBIT = inhibitM;
    endtask

    // Plays memory for one granted transfer starting at the IDLE cycle (c=0).
    // Ready arrives on bus cycle k (c=k+1) unless tmo, in which case never.
    task automatic runTransfer(input bit expData, input int k, input bit tmo,
                               input logic [31:0] rd, input logic er, input bit drop,
                               input logic [ADDR_W-1:0] expAddr, input logic expWe,
                               input logic [3:0] expBe, input logic [31:0] expWd);
        int reqCycles = 0;
        int ackCycle  = -1;
        for (int c = 0; (c < TIMEOUT + 6) && (ackCycle < 0); c++) begin
            if (c > 0) begin
                @(posedge CLK);
                #1;
                if (drop && (c == 1)) begin
                    if (expData) begin
                        D_RE = 1'b0;
                        D_WE = 1'b0;
                    end else begin
                        I_REQ = 1'b0;
                    end
                end
            end
            M_READY = !tmo && (c == k + 1);
            M_RDATA = M_READY ? rd : $urandom;
            M_ERR   = M_READY ? er : 1'b0;
            @(negedge CLK);
            if (c == 0) begin
                checkOutput("idleNoReq", M_REQ, 0);
                checkOutput("idleStall", STALL, 1);
            end
            if (c == 1) begin
                checkOutput("busAddr", M_ADDR, expAddr);
                checkOutput("busWe", M_WE, expWe);
                checkOutput("busBe", M_BE, expBe);
                if (expWe) checkOutput("busWd", M_WD, expWd);
            end
            if (M_REQ) reqCycles++;
            if (I_ACK || D_ACK) begin
                ackCycle = c;
                checkOutput("ackPort", {I_ACK, D_ACK}, expData ? 2'b01 : 2'b10);
                if (expData) begin
                    if (!tmo && !expWe) dRdModel = rd;
                    checkOutput("dRdata", D_RDATA, dRdModel);
                    checkOutput("dErr", D_ERR, tmo ? 1'b1 : er);
                end else begin
                    if (!tmo) iRdModel = rd;
                    checkOutput("iRdata", I_RDATA, iRdModel);
                    checkOutput("iErr", I_ERR, tmo ? 1'b1 : er);
                end
            end
        end
        checkOutput("ackLatency", ackCycle, tmo ? TIMEOUT + 1 : k + 2);
        checkOutput("reqCycles", reqCycles, tmo ? TIMEOUT : k + 1);
        M_READY = 1'b0;
        M_ERR   = 1'b0;
    endtask

    // One arbitration round from the next IDLE cycle using the pending intent
    task automatic applyStimulus(input int k, input bit tmo, input logic [31:0] rd,
                                 input logic er, input bit drop);
        bit dValid;
        bit win;
        @(posedge CLK);
        #1;
        driveRequests();
        dValid = dPend && !inhibitM;
        if (!dValid && !iPend) begin
            @(negedge CLK);
            checkOutput("noIssueReq", M_REQ, 0);
            checkOutput("noIssueStall", STALL, 0);
            checkOutput("noIssueAck", {I_ACK, D_ACK}, 0);
            return;
        end
        win = dValid && (!iPend || !lastWasData);
        if (win) begin
            runTransfer(1'b1, k, tmo, rd, er, drop, dAddrM, dWrite,
                        dWrite ? dBeM : 4'hF, dWdM);
            dPend = 1'b0;
        end else begin
            runTransfer(1'b0, k, tmo, rd, er, drop, iAddrM, 1'b0, 4'hF, 32'h0);
            iPend = 1'b0;
        end
        lastWasData = win;
    endtask

    task automatic newInst(input logic [ADDR_W-1:0] a);
        iPend  = 1'b1;
        iAddrM = a;
    endtask

    task automatic newData(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
        dPend  = 1'b1;
        dWrite = wr;
        dAddrM = a;
        dWdM   = wd;
        dBeM   = be;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        iPend       = 1'b0;
        iAddrM      = '0;
        dPend       = 1'b0;
        dWrite      = 1'b0;
        dAddrM      = '0;
        dWdM        = '0;
        dBeM        = '0;
        inhibitM    = 1'b0;
        lastWasData = 1'b0;
        iRdModel    = '0;
        dRdModel    = '0;
        RESET       = 1'b1;
        M_READY     = 1'b0;
        M_ERR       = 1'b0;
        M_RDATA     = '0;
        driveRequests();

        repeat (3) @(negedge CLK);
        checkOutput("rstMReq", M_REQ, 0);
        checkOutput("rstAcks", {I_ACK, D_ACK, I_ERR, D_ERR}, 0);
        checkOutput("rstRdata", {I_RDATA, D_RDATA}, 0);
        checkOutput("rstBus", {M_WE, M_ADDR, M_WD, M_BE}, 0);
        checkOutput("rstStall", STALL, 0);
        RESET = 1'b0;

        // Lone ifetch, zero-wait memory
        newInst(30'h100);
        applyStimulus(0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);

        // Simultaneous write and ifetch, then repeated writes alternate with ifetch
        newData(1'b1, 30'h2A0, 32'h12345678, 4'b0110);
        newInst(30'h104);
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 32'hCAFE0001, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            if (!dPend) newData(1'b1, 30'h300 + 30'(r), $urandom, 4'(r + 1));
            if (!iPend) newInst(30'h200 + 30'(r));
            applyStimulus(0, 1'b0, $urandom, 1'b0, 1'b0);
        end
        while (iPend || dPend) applyStimulus(0, 1'b0, $urandom, 1'b0, 1'b0);

        // Data read held off by INHIBIT, then released
        newData(1'b0, 30'h55, 32'h0, 4'h0);
        inhibitM = 1'b1;
        for (int r = 0; r < 5; r++) applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);
        inhibitM = 1'b0;
        applyStimulus(2, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);

        // Data read that times out
        newData(1'b0, 30'h77, 32'h0, 4'h0);
        applyStimulus(0, 1'b1, 32'h0, 1'b0, 1'b0);

        // Ifetch completing with a memory error
        newInst(30'h3FF0);
        applyStimulus(1, 1'b0, 32'hBADC0DE5, 1'b1, 1'b0);

        // Randomized mixed traffic
        for (int it = 0; it < 60; it++) begin
            if (!iPend && ($urandom_range(0, 1) == 1)) newInst(30'($urandom));
            if (!dPend && ($urandom_range(0, 1) == 1))
                newData(1'($urandom), 30'($urandom), $urandom, 4'($urandom));
            inhibitM = ($urandom_range(0, 4) == 0);
            applyStimulus($urandom_range(0, 2), $urandom_range(0, 7) == 0, $urandom,
                          1'($urandom_range(0, 5) == 0), $urandom_range(0, 3) == 0);
        end
        inhibitM = 1'b0;
        while (iPend || dPend) applyStimulus(0, 1'b0, $urandom, 1'b0, 1'b0);

        // Reset in the middle of a transfer
        @(posedge CLK);
        #1;
        I_REQ  = 1'b1;
        I_ADDR = 30'h4000;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("preRstReq", M_REQ, 1);
        #1;
        RESET = 1'b1;
        #1;
        checkOutput("asyncRstReq", M_REQ, 0);
        @(negedge CLK);
        checkOutput("rstNoAck", {I_ACK, D_ACK}, 0);
        RESET   = 1'b0;
        I_REQ   = 1'b0;
        @(negedge CLK);
        checkOutput("postRstNoAck", {I_ACK, D_ACK, M_REQ}, 0);
        lastWasData = 1'b0;
        iRdModel    = '0;
        dRdModel    = '0;
        newInst(30'h4004);
        applyStimulus(1, 1'b0, 32'h0BADF00D, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
